// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
package mem_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker: ls over if by default; alternating on ties when
// MEM_ARB_RR_EN is defined.
module arb_pick
  import mem_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  owner_e last,
`endif
  input  logic   if_req,
  input  logic   ls_req,
  output logic   any,
  output owner_e win
);

  always_comb begin
    any = if_req | ls_req;
    win = OWN_IF;
`ifdef MEM_ARB_RR_EN
    // On a tie the side that was not granted last time goes first.
    if (if_req && ls_req) begin
      win = (last == OWN_LS) ? OWN_IF : OWN_LS;
    end else if (ls_req) begin
      win = OWN_LS;
    end
`else
    if (ls_req) begin
      win = OWN_LS;
    end
`endif
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates fetch and load/store ports onto one memory bus, one transaction
// at a time. Define MEM_ARB_RR_EN for round-robin instead of fixed ls priority.
module mem_arb
  import mem_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            err
);

  arb_state_e state, state_nxt;
  owner_e     owner;
  logic       pick_any;
  owner_e     pick_win;
  logic       take;
  logic       rsp;

  // The owner register doubles as the last-granted record for round-robin.
  arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last   (owner),
`endif
    .if_req (if_req),
    .ls_req (ls_req),
    .any    (pick_any),
    .win    (pick_win)
  );

  // Next state plus the combinational grant and response routing.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    rsp       = 1'b0;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;
    case (state)
      IDLE: begin
        if (pick_any && !rst) begin
          take      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          rsp       = !rst;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if_gnt    = take && (pick_win == OWN_IF);
    ls_gnt    = take && (pick_win == OWN_LS);
    if_rvalid = rsp && (owner == OWN_IF);
    ls_rvalid = rsp && (owner == OWN_LS);
    if (if_rvalid) if_rdata = mem_rdata;
    if (ls_rvalid) ls_rdata = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_req <= (state_nxt == REQ);
      busy    <= (state_nxt != IDLE);
      if (take) begin
        owner <= pick_win;
        if (pick_win == OWN_LS) begin
          mem_we    <= ls_we;
          mem_be    <= ls_be;
          mem_addr  <= ls_addr;
          mem_wdata <= ls_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_be    <= '1;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      // Out-of-protocol memory events are flagged and otherwise ignored.
      if ((mem_rvalid && state != WAIT) || (mem_gnt && state != REQ)) begin
        err <= 1'b1;
      end
    end
  end

endmodule
